// File: rtl/alu_share_if.sv
// Bundle between the two ALU requesters, the shared-ALU arbiter and the result consumer.
// The master side drives requests, operands and res_ready; the slave side is the arbiter.
interface alu_share_if #(
  parameter int WIDTH = 32
);
  logic             req0;
  logic [1:0]       aluop0;
  logic [5:0]       func0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             gnt0;

  logic             req1;
  logic [1:0]       aluop1;
  logic [5:0]       func1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt1;

  logic             res_valid;
  logic             res_ready;
  logic             res_id;
  logic [WIDTH-1:0] res;
  logic             res_zero;

  modport master (
    output req0, aluop0, func0, a0, b0,
    output req1, aluop1, func1, a1, b1,
    output res_ready,
    input  gnt0, gnt1,
    input  res_valid, res_id, res, res_zero
  );

  modport slave (
    input  req0, aluop0, func0, a0, b0,
    input  req1, aluop1, func1, a1, b1,
    input  res_ready,
    output gnt0, gnt1,
    output res_valid, res_id, res, res_zero
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// One MIPS ALU datapath shared round-robin between two requesters, with a single
// registered result slot that supports back-to-back grants and consumer backpressure.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  alu_share_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_SLT
  } alu_op_e;

  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_SLT = 6'b101010;

  function automatic alu_op_e decode_op(input logic [1:0] aluop, input logic [5:0] func);
    alu_op_e op;
    op = OP_ADD;
    case (aluop)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b11: op = OP_AND;
      default: begin
        case (func)
          FUNC_ADD: op = OP_ADD;
          FUNC_SUB: op = OP_SUB;
          FUNC_AND: op = OP_AND;
          FUNC_OR:  op = OP_OR;
          FUNC_SLT: op = OP_SLT;
          default:  op = OP_ADD;
        endcase
      end
    endcase
    return op;
  endfunction

  // add/sub wrap silently; slt compares as two's complement and zero-extends the flag
  function automatic logic [WIDTH-1:0] alu_eval(input alu_op_e op,
                                                input logic signed [WIDTH-1:0] a,
                                                input logic signed [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, (a < b)};
      default: r = a + b;
    endcase
    return r;
  endfunction

  logic                    ptr;
  logic                    can_accept;
  logic                    gnt0_p0;
  logic                    gnt1_p0;
  logic                    vld_p0;
  logic                    id_p0;
  alu_op_e                 op_p0;
  logic signed [WIDTH-1:0] a_p0;
  logic signed [WIDTH-1:0] b_p0;
  logic        [WIDTH-1:0] result_p0;

  logic                    vld_p1;
  logic                    id_p1;
  logic        [WIDTH-1:0] res_p1;
  logic                    zero_p1;

  // ---- p0: arbitration, operand select, decode and compute ----
  assign can_accept = !vld_p1 || bus.res_ready;

  always_comb begin
    gnt0_p0 = 1'b0;
    gnt1_p0 = 1'b0;
    if (!rst && can_accept) begin
      if (bus.req0 && bus.req1) begin
        gnt0_p0 = !ptr;
        gnt1_p0 = ptr;
      end else begin
        gnt0_p0 = bus.req0;
        gnt1_p0 = bus.req1;
      end
    end
  end

  assign vld_p0 = gnt0_p0 || gnt1_p0;
  assign id_p0  = gnt1_p0;

  always_comb begin
    op_p0 = decode_op(bus.aluop0, bus.func0);
    a_p0  = bus.a0;
    b_p0  = bus.b0;
    if (id_p0) begin
      op_p0 = decode_op(bus.aluop1, bus.func1);
      a_p0  = bus.a1;
      b_p0  = bus.b1;
    end
  end

  assign result_p0 = alu_eval(op_p0, a_p0, b_p0);

  // ---- p1: result register; a grant overwrites, an idle drain only clears valid ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      id_p1   <= 1'b0;
      res_p1  <= '0;
      zero_p1 <= 1'b1;
      ptr     <= 1'b0;
    end else if (vld_p0) begin
      vld_p1  <= 1'b1;
      id_p1   <= id_p0;
      res_p1  <= result_p0;
      zero_p1 <= (result_p0 == '0);
      ptr     <= !id_p0;
    end else if (bus.res_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.gnt0      = gnt0_p0;
  assign bus.gnt1      = gnt1_p0;
  assign bus.res_valid = vld_p1;
  assign bus.res_id    = id_p1;
  assign bus.res       = res_p1;
  assign bus.res_zero  = zero_p1;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: reset, decode, signed/wrap, round robin,
// backpressure and idle drain, each checked against hand-computed values.
module tb_alu_share_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  alu_share_if #(.WIDTH(32)) bus ();

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // requester 0 alone: grant in the drive cycle, result after the next edge
  task automatic op0(input string tag, input logic [1:0] op, input logic [5:0] f,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk);
    bus.req0 = 1'b1; bus.aluop0 = op; bus.func0 = f; bus.a0 = a; bus.b0 = b;
    bus.res_ready = 1'b1;
    #1;
    chk({tag, "_gnt0"}, {31'd0, bus.gnt0}, 32'd1);
    chk({tag, "_gnt1"}, {31'd0, bus.gnt1}, 32'd0);
    @(posedge clk);
    #1;
    bus.req0 = 1'b0;
    chk({tag, "_valid"}, {31'd0, bus.res_valid}, 32'd1);
    chk({tag, "_res"},   bus.res, exp);
    chk({tag, "_id"},    {31'd0, bus.res_id}, 32'd0);
    chk({tag, "_zero"},  {31'd0, bus.res_zero}, (exp == 32'd0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.req0 = 1'b1; bus.aluop0 = 2'b00; bus.func0 = 6'd0; bus.a0 = 32'd1; bus.b0 = 32'd1;
    bus.req1 = 1'b0; bus.aluop1 = 2'b00; bus.func1 = 6'd0; bus.a1 = 32'd0; bus.b1 = 32'd0;
    bus.res_ready = 1'b0;
    #1;
    chk("rst_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_res",   bus.res, 32'd0);
    chk("rst_zero",  {31'd0, bus.res_zero}, 32'd1);
    chk("rst_id",    {31'd0, bus.res_id}, 32'd0);
    chk("rst_gnt0",  {31'd0, bus.gnt0}, 32'd0);
    @(negedge clk);
    bus.req0 = 1'b0;
    rst = 1'b0;

    op0("dec_sub", 2'b10, 6'b100010, 32'd7, 32'd5, 32'd2);
    op0("dec_or",  2'b10, 6'b100101, 32'd7, 32'd5, 32'd7);
    op0("dec_and", 2'b11, 6'b000000, 32'd7, 32'd5, 32'd5);
    op0("dec_dft", 2'b10, 6'b111111, 32'd7, 32'd5, 32'd12);
    op0("dec_a01", 2'b01, 6'b100101, 32'd7, 32'd5, 32'd2);
    op0("slt_neg", 2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd1);
    op0("add_wrap", 2'b00, 6'b000000, 32'hFFFF_FFFF, 32'd1, 32'd0);
    op0("pre_rst", 2'b00, 6'b000000, 32'd7, 32'd5, 32'd12);

    // hold the result unconsumed, then reset with both requesters waiting
    bus.res_ready = 1'b0;
    @(negedge clk);
    chk("hold_valid", {31'd0, bus.res_valid}, 32'd1);
    rst = 1'b1;
    bus.req0 = 1'b1; bus.aluop0 = 2'b00; bus.a0 = 32'd10; bus.b0 = 32'd1;
    bus.req1 = 1'b1; bus.aluop1 = 2'b01; bus.a1 = 32'd20; bus.b1 = 32'd3;
    #1;
    chk("mrst_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("mrst_res",   bus.res, 32'd0);
    chk("mrst_zero",  {31'd0, bus.res_zero}, 32'd1);
    chk("mrst_id",    {31'd0, bus.res_id}, 32'd0);
    chk("mrst_gnt0",  {31'd0, bus.gnt0}, 32'd0);
    chk("mrst_gnt1",  {31'd0, bus.gnt1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.res_ready = 1'b1;
    #1;

    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      chk($sformatf("rr%0d_gnt0", i), {31'd0, bus.gnt0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_gnt1", i), {31'd0, bus.gnt1}, (i % 2 == 1) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d_id", i),    {31'd0, bus.res_id}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_res", i),   bus.res, (i % 2 == 1) ? 32'd17 : 32'd11);
      chk($sformatf("rr%0d_valid", i), {31'd0, bus.res_valid}, 32'd1);
    end

    // backpressure: requester 1 waits behind an unconsumed result
    bus.req0 = 1'b0;
    bus.res_ready = 1'b0;
    bus.aluop1 = 2'b00; bus.a1 = 32'd100; bus.b1 = 32'd23;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("bp%0d_gnt1", i),  {31'd0, bus.gnt1}, 32'd0);
      chk($sformatf("bp%0d_res", i),   bus.res, 32'd17);
      chk($sformatf("bp%0d_valid", i), {31'd0, bus.res_valid}, 32'd1);
    end
    @(negedge clk);
    bus.res_ready = 1'b1;
    #1;
    chk("bp_rel_gnt1", {31'd0, bus.gnt1}, 32'd1);
    @(posedge clk);
    #1;
    bus.req1 = 1'b0;
    chk("bp_res",   bus.res, 32'd123);
    chk("bp_id",    {31'd0, bus.res_id}, 32'd1);
    chk("bp_valid", {31'd0, bus.res_valid}, 32'd1);

    // idle drain: valid drops, payload holds
    @(posedge clk);
    #1;
    chk("drain_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("drain_res",   bus.res, 32'd123);
    chk("drain_id",    {31'd0, bus.res_id}, 32'd1);
    chk("drain_zero",  {31'd0, bus.res_zero}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
